// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit add/subtract, one CHUNK-bit slice per register stage, with
// valid/ready flow control and carry/overflow/zero flags registered at the last stage.
module pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             en,
  input  logic             sub,
  input  logic             c0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sout,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int CHUNK = WIDTH / STAGES;
  localparam int LAST  = STAGES - 1;

  logic             advance;
  logic [WIDTH-1:0] b_pre;
  logic [WIDTH-1:0] sout_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;

  assign b_pre = sub ? ~in2 : in2;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * CHUNK;

    // a_in/b_in hold this stage's chunk in the low bits plus every chunk above it
    logic [WIDTH-LO-1:0]   a_in;
    logic [WIDTH-LO-1:0]   b_in;
    logic                  c_in;
    logic                  v_in;
    logic                  kill_in;
    logic [CHUNK:0]        add_d;
    logic [LO+CHUNK-1:0]   sum_d;
    logic                  vld_q;

    if (k == 0) begin : g_entry
      assign a_in    = in1;
      assign b_in    = b_pre;
      assign c_in    = c0 ^ sub;
      assign v_in    = in_valid;
      assign kill_in = ~en;
      assign sum_d   = add_d[CHUNK-1:0];
    end else begin : g_link
      assign a_in    = g_stage[k-1].g_mid.a_q;
      assign b_in    = g_stage[k-1].g_mid.b_q;
      assign c_in    = g_stage[k-1].g_mid.cy_q;
      assign v_in    = g_stage[k-1].vld_q;
      assign kill_in = g_stage[k-1].g_mid.kill_q;
      assign sum_d   = {add_d[CHUNK-1:0], g_stage[k-1].g_mid.s_q};
    end

    assign add_d = {1'b0, a_in[CHUNK-1:0]} + {1'b0, b_in[CHUNK-1:0]} + {{CHUNK{1'b0}}, c_in};

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q <= 1'b0;
      end else if (advance) begin
        vld_q <= v_in;
      end
    end

    if (k < LAST) begin : g_mid
      logic [WIDTH-LO-CHUNK-1:0] a_q;
      logic [WIDTH-LO-CHUNK-1:0] b_q;
      logic [LO+CHUNK-1:0]       s_q;
      logic                      cy_q;
      logic                      kill_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q    <= '0;
          b_q    <= '0;
          s_q    <= '0;
          cy_q   <= 1'b0;
          kill_q <= 1'b0;
        end else if (advance) begin
          a_q    <= a_in[WIDTH-LO-1:CHUNK];
          b_q    <= b_in[WIDTH-LO-1:CHUNK];
          s_q    <= sum_d;
          cy_q   <= add_d[CHUNK];
          kill_q <= kill_in;
        end
      end
    end else begin : g_out
      // Carry into the MSB recovered from the MSB sum bit and its two operand bits
      logic msb_cin;
      assign msb_cin = a_in[CHUNK-1] ^ b_in[CHUNK-1] ^ sum_d[WIDTH-1];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sout_q <= '0;
          cout_q <= 1'b0;
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (advance && v_in) begin
          if (kill_in) begin
            sout_q <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b1;
          end else begin
            sout_q <= sum_d;
            cout_q <= add_d[CHUNK];
            ovf_q  <= add_d[CHUNK] ^ msb_cin;
            zero_q <= ~|sum_d;
          end
        end
      end
    end
  end

  assign out_valid = g_stage[LAST].vld_q;
  assign advance   = ~out_valid | out_ready;
  assign in_ready  = advance;
  assign sout      = sout_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: doc/pipe_adder.md
Name: pipe_adder

Overview:
Parametrised, pipelined successor to the single-cycle integer adder used in the NPC execute path. Splits a WIDTH-bit add/subtract into STAGES carry-chained chunks, one chunk per register stage, with valid/ready flow control on both sides. Produces sum, carry-out, signed overflow and zero flags for the ALU and branch-compare logic. Accepts one operation per cycle when not back-pressured.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of STAGES.
STAGES, 4, pipeline depth = number of chunks; CHUNK = WIDTH/STAGES; STAGES >= 1.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operation present on inputs
in_ready  output  1  block can accept an operation this cycle
en  input  1  1 = compute; 0 = result forced to all-zero, flags cout=0, ovf=0, zero=1
sub  input  1  0 = in1+in2+c0; 1 = in1+~in2+!c0 (c0=0 gives in1-in2; c0=1 gives in1-in2-1)
c0  input  1  carry-in / borrow-in
in1  input  WIDTH  operand A
in2  input  WIDTH  operand B
out_valid  output  1  result present on outputs
out_ready  input  1  consumer takes result this cycle
sout  output  WIDTH  sum/difference
cout  output  1  carry-out of MSB chunk (for sub: 1 = no borrow)
ovf  output  1  signed overflow
zero  output  1  sout == 0

Behaviour:
- Reset (async, rst=1): all stage valid bits cleared; out_valid=0; sout=0, cout=0, ovf=0, zero=0. Reset mid-operation discards every in-flight op; no result appears after reset release for ops accepted before it.
- Operand prep at entry: B' = sub ? ~in2 : in2; carry-in = c0 ^ sub. en=0 captured as a per-op kill bit carried down the pipe.
- Stage k (0..STAGES-1) adds chunk k of A and B' plus carry from stage k-1 (stage 0 uses entry carry); registers its CHUNK sum bits, carry-out, and the not-yet-added upper chunks of A and B'. Lower finished sum chunks travel forward unchanged.
- Latency: exactly STAGES cycles from accept (in_valid & in_ready) to out_valid, with no stall.
- Flags computed at final stage: cout = MSB chunk carry-out; ovf = carry into MSB XOR carry out of MSB; zero = (sout == 0). Killed ops (en=0): sout=0, cout=0, ovf=0, zero=1.
- Flow control: global advance = !out_valid | out_ready. in_ready = advance. When advance=1 every stage shifts one step; stage 0 loads a valid op iff in_valid. When advance=0 all stages hold, outputs held stable (sout/flags must not change while out_valid & !out_ready).
- Bubbles are not collapsed; throughput 1 op/cycle with out_ready held high.
- in_valid with in_ready=0: op not accepted; source must hold it. Inputs ignored when in_valid=0.
- Data order strictly preserved; no op dropped or duplicated.
- STAGES=1: single register stage, latency 1, same handshake.
- Width rule: all arithmetic modulo 2^WIDTH; cout is the (WIDTH+1)th bit.

Test Plan:
- Reset: assert rst mid-stream with 3 ops in flight -> out_valid=0 immediately, no stale results after release; first new op appears exactly 4 cycles after accept.
- Add carry chain (WIDTH=32,STAGES=4): in1=0xFFFFFFFF, in2=0x00000001, c0=0, sub=0 -> sout=0x00000000, cout=1, ovf=0, zero=1 after 4 cycles.
- Subtract/overflow: in1=0x80000000, in2=0x00000001, sub=1, c0=0 -> sout=0x7FFFFFFF, cout=1, ovf=1, zero=0; in1=5,in2=7,sub=1 -> sout=0xFFFFFFFE, cout=0, ovf=0.
- Kill: en=0, in1=0x12345678, in2=0x1 -> sout=0, cout=0, ovf=0, zero=1.
- Back-pressure: stream 8 random ops with out_ready toggling 1,0,0,1 -> in_ready tracks advance, outputs stable while stalled, 8 results in order matching a reference model, none lost.
- Parametric: WIDTH=8,STAGES=1 and WIDTH=64,STAGES=8, 1000 random ops each, out_ready=1 -> full throughput, latency = STAGES, all results match model.
